// File: rtl/xbus_avm_pkg.sv
// ============================================================================
// Module      : xbus_avm_pkg
// Description : Shared types and constants for the XBUS to Avalon-MM bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xbus_avm_pkg;

    localparam int unsigned c_ADDR_W = 32;
    localparam int unsigned c_DATA_W = 32;
    localparam int unsigned c_BE_W   = 4;

    localparam logic [c_ADDR_W-1:0] c_ADDR_BASE_DEF = 32'h9000_0000;
    localparam logic [c_ADDR_W-1:0] c_ADDR_MASK_DEF = 32'hFF00_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/xbus_avm_bridge.sv
// ============================================================================
// Module      : xbus_avm_bridge
// Description : Single-outstanding XBUS to Avalon-MM master bridge with
//               address window decode. Define XBUS_AVM_TIMEOUT_EN to enable
//               the ACCESS-phase timeout (bus error after TIMEOUT_CYC cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbus_avm_bridge
    import xbus_avm_pkg::*;
#(
    parameter logic [c_ADDR_W-1:0] ADDR_BASE = c_ADDR_BASE_DEF,
    parameter logic [c_ADDR_W-1:0] ADDR_MASK = c_ADDR_MASK_DEF
`ifdef XBUS_AVM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [c_ADDR_W-1:0] xbus_adr_i,
    input  logic [c_DATA_W-1:0] xbus_dat_i,
    input  logic                xbus_we_i,
    input  logic [c_BE_W-1:0]   xbus_sel_i,
    input  logic                xbus_stb_i,
    input  logic                xbus_cyc_i,
    output logic [c_DATA_W-1:0] xbus_dat_o,
    output logic                xbus_ack_o,
    output logic                xbus_err_o,
    output logic                avm_cs_o,
    output logic [c_ADDR_W-1:0] avm_address_o,
    output logic                avm_read_o,
    output logic                avm_write_o,
    output logic [c_DATA_W-1:0] avm_writedata_o,
    output logic [c_BE_W-1:0]   avm_byteenable_o,
    input  logic                avm_waitrequest_i,
    input  logic [c_DATA_W-1:0] avm_readdata_i
);

    state_t              r_state, w_state_nxt;
    logic                r_cs, w_cs_nxt;
    logic                r_rd, w_rd_nxt;
    logic                r_wr, w_wr_nxt;
    logic                r_we, w_we_nxt;
    logic [c_ADDR_W-1:0] r_adr, w_adr_nxt;
    logic [c_DATA_W-1:0] r_wdat, w_wdat_nxt;
    logic [c_BE_W-1:0]   r_be, w_be_nxt;
    logic [c_DATA_W-1:0] r_rdat, w_rdat_nxt;
    logic                r_ack, w_ack_nxt;
    logic                r_err, w_err_nxt;
    logic                r_abort, w_abort_nxt;
    logic                w_hit;
    logic                w_timeout;

    assign w_hit = ((xbus_adr_i & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));

`ifdef XBUS_AVM_TIMEOUT_EN
    localparam int unsigned c_TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [c_TO_W-1:0] r_to_cnt;

    // Counter reads 0 on the first ACCESS cycle, so TIMEOUT_CYC-1 marks the last one.
    assign w_timeout = (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state != ST_ACCESS)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cs    <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_be    <= '0;
            r_rdat  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cs    <= w_cs_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_we    <= w_we_nxt;
            r_adr   <= w_adr_nxt;
            r_wdat  <= w_wdat_nxt;
            r_be    <= w_be_nxt;
            r_rdat  <= w_rdat_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cs_nxt    = r_cs;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
        w_we_nxt    = r_we;
        w_adr_nxt   = r_adr;
        w_wdat_nxt  = r_wdat;
        w_be_nxt    = r_be;
        w_rdat_nxt  = r_rdat;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_abort_nxt = r_abort;
        case (r_state)
            ST_IDLE: begin
                w_abort_nxt = 1'b0;
                if (xbus_stb_i && xbus_cyc_i) begin
                    if (w_hit) begin
                        w_adr_nxt   = xbus_adr_i;
                        w_wdat_nxt  = xbus_dat_i;
                        w_be_nxt    = xbus_sel_i;
                        w_we_nxt    = xbus_we_i;
                        w_cs_nxt    = 1'b1;
                        w_rd_nxt    = ~xbus_we_i;
                        w_wr_nxt    = xbus_we_i;
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // Avalon cannot cancel a transfer; an abort only mutes the ack.
                if (!xbus_cyc_i) begin
                    w_abort_nxt = 1'b1;
                end
                if (!avm_waitrequest_i) begin
                    w_cs_nxt    = 1'b0;
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_rdat_nxt  = r_we ? '0 : avm_readdata_i;
                    w_state_nxt = ST_RESP;
                end else if (w_timeout) begin
                    w_cs_nxt    = 1'b0;
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESP: begin
                w_ack_nxt   = ~r_abort;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign xbus_dat_o       = r_rdat;
    assign xbus_ack_o       = r_ack;
    assign xbus_err_o       = r_err;
    assign avm_cs_o         = r_cs;
    assign avm_address_o    = r_adr;
    assign avm_read_o       = r_rd;
    assign avm_write_o      = r_wr;
    assign avm_writedata_o  = r_wdat;
    assign avm_byteenable_o = r_be;

endmodule

`default_nettype wire
